// File: rtl/accel_pkg.sv
// accel_pkg: shared types, constants and helpers for the accelerometer
// burst-read frame assembler.
//   state_t   - frame assembler FSM states
//   axis_t    - axis index (X=0, Y=1, Z=2)
//   READ_CMD / XDATA_L_ADDR - command and address bytes that open a burst
//   sx_ok()   - checks the sign-extension bits of a high data byte
package accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_DATA,
    ST_WAIT_END
  } state_t;

  localparam logic [7:0] READ_CMD     = 8'h0B;
  localparam logic [7:0] XDATA_L_ADDR = 8'h0E;

  localparam int AXIS_W = 2;
  typedef logic [AXIS_W-1:0] axis_t;

  // The high byte carries sample bits [data_w-9:0]; every bit above that
  // must repeat bit data_w-9 (the sample sign).
  function automatic logic sx_ok(input logic [7:0] hi_byte, input int data_w);
    logic ok;
    ok = 1'b1;
    for (int i = data_w - 8; i < 8; i++) begin
      if (hi_byte[i] != hi_byte[data_w-9]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/byte_pair_unpack.sv
// byte_pair_unpack: holds the low data byte of an axis and assembles it
// with the following high byte into one DATA_W-bit sample.
//   clk, rst    - clock, asynchronous active-high reset
//   i_valid     - a data byte is being accepted this cycle
//   i_odd       - the accepted byte is the high byte of its pair
//   i_byte      - the received byte
//   o_valid     - a complete pair is presented this cycle
//   o_data      - assembled sample {hi[DATA_W-9:0], lo}
//   o_fmt_bad   - high byte sign-extension bits disagree with the sign bit
// The pair is presented in the same cycle as the high byte so a high byte
// that arrives together with frame_end can still be committed on that edge.
module byte_pair_unpack
  import accel_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_odd,
  input  logic [7:0]        i_byte,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_fmt_bad
);

  logic [7:0] r_lo_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo_hold <= '0;
    end else if (i_valid && !i_odd) begin
      r_lo_hold <= i_byte;
    end
  end

  assign o_valid   = i_valid && i_odd;
  assign o_data    = {i_byte[DATA_W-9:0], r_lo_hold};
  assign o_fmt_bad = o_valid && !sx_ok(i_byte, DATA_W);

endmodule

// File: rtl/accel_frame_assembler.sv
// accel_frame_assembler: turns the MISO byte stream of an accelerometer
// burst read into X/Y/Z samples behind a valid/ready output register.
//   clk, rst           - clock, asynchronous active-high reset
//   frame_start/end    - one-cycle pulses on CS fall / rise
//   rx_valid, rx_byte  - received byte strobe and value
//   out_ready          - consumer accepts the presented sample set
//   clear_status       - clears fmt_err and overrun
//   out_valid          - sample_x/y/z hold unconsumed data
//   sample_x/y/z       - signed samples of the last committed frame
//   frame_err          - one-cycle pulse on short or aborted frame
//   fmt_err, overrun   - sticky format / overwrite flags
//   frame_cnt          - committed frame counter (wraps)
module accel_frame_assembler
  import accel_pkg::*;
#(
  parameter int SKIP_BYTES = 2,
  parameter int AXES       = 3,
  parameter int DATA_W     = 12,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     out_ready,
  input  logic                     clear_status,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] sample_x,
  output logic signed [DATA_W-1:0] sample_y,
  output logic signed [DATA_W-1:0] sample_z,
  output logic                     frame_err,
  output logic                     fmt_err,
  output logic                     overrun,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int     MAX_IDX     = (SKIP_BYTES > 2*AXES) ? SKIP_BYTES : 2*AXES;
  localparam int     IDX_W       = $clog2(MAX_IDX + 1);
  localparam int     LAST_DATA   = 2*AXES - 1;
  localparam int     LAST_SKIP   = (SKIP_BYTES > 0) ? SKIP_BYTES - 1 : 0;
  localparam state_t START_STATE = (SKIP_BYTES == 0) ? ST_DATA : ST_SKIP;

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic               w_data_en;
  logic               w_commit;
  logic               w_abort_err;

  logic               w_pair_valid;
  logic [DATA_W-1:0]  w_pair_data;
  logic               w_fmt_bad;
  axis_t              w_axis;

  logic [DATA_W-1:0]  w_commit_val [AXES];

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_sample_x, r_sample_y, r_sample_z;
  logic               r_frame_err;
  logic               r_fmt_err;
  logic               r_overrun;
  logic [CNT_W-1:0]   r_frame_cnt;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_data_en    = 1'b0;
    w_commit     = 1'b0;
    w_abort_err  = 1'b0;
    if (frame_start) begin
      // Restart from any state; a byte in the same cycle is dropped.
      // Leaving WAIT_END drops an uncommitted but complete frame silently.
      w_idx_next   = '0;
      w_state_next = START_STATE;
      w_abort_err  = (r_state == ST_SKIP) || (r_state == ST_DATA);
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_IDLE;
        end
        ST_SKIP: begin
          if (rx_valid) begin
            if (r_idx == IDX_W'(LAST_SKIP)) begin
              w_idx_next   = '0;
              w_state_next = ST_DATA;
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end
          if (frame_end) begin
            w_abort_err  = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            w_data_en = 1'b1;
            if (r_idx == IDX_W'(LAST_DATA)) begin
              w_state_next = ST_WAIT_END;
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end
          // The byte above is consumed first, so a final byte arriving
          // with frame_end completes the frame.
          if (frame_end) begin
            if (rx_valid && (r_idx == IDX_W'(LAST_DATA))) begin
              w_commit = 1'b1;
            end else begin
              w_abort_err = 1'b1;
            end
            w_state_next = ST_IDLE;
          end
        end
        ST_WAIT_END: begin
          if (frame_end) begin
            w_commit     = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------- byte pairing ----------------
  assign w_axis = axis_t'(r_idx >> 1);

  byte_pair_unpack #(
    .DATA_W (DATA_W)
  ) u_unpack (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_data_en),
    .i_odd     (r_idx[0]),
    .i_byte    (rx_byte),
    .o_valid   (w_pair_valid),
    .o_data    (w_pair_data),
    .o_fmt_bad (w_fmt_bad)
  );

  // Per-axis shadow; the commit path forwards a pair completing in the
  // commit cycle so the last high byte need not be registered first.
  for (genvar gi = 0; gi < AXES; gi++) begin : g_axis
    logic [DATA_W-1:0] r_shadow;
    logic              w_hit;

    assign w_hit = w_pair_valid && (w_axis == axis_t'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_shadow <= '0;
      end else if (frame_start) begin
        r_shadow <= '0;
      end else if (w_hit) begin
        r_shadow <= w_pair_data;
      end
    end

    assign w_commit_val[gi] = w_hit ? w_pair_data : r_shadow;
  end

  // ---------------- output register and status ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sample_x  <= '0;
      r_sample_y  <= '0;
      r_sample_z  <= '0;
      r_frame_err <= 1'b0;
      r_fmt_err   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_frame_err <= w_abort_err;

      if (w_commit) begin
        r_sample_x  <= w_commit_val[0];
        r_sample_y  <= w_commit_val[1];
        r_sample_z  <= w_commit_val[2];
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Set events take priority over clear_status.
      if (w_commit && r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end else if (clear_status) begin
        r_overrun <= 1'b0;
      end

      if (w_fmt_bad) begin
        r_fmt_err <= 1'b1;
      end else if (clear_status) begin
        r_fmt_err <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sample_x  = r_sample_x;
  assign sample_y  = r_sample_y;
  assign sample_z  = r_sample_z;
  assign frame_err = r_frame_err;
  assign fmt_err   = r_fmt_err;
  assign overrun   = r_overrun;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_accel_frame_assembler.sv
// Testbench for accel_frame_assembler: directed scenarios plus randomized
// frames, checked by a commit scoreboard and status checks.
module tb_accel_frame_assembler;
  import accel_pkg::*;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start, frame_end, rx_valid, out_ready, clear_status;
  logic [7:0]        rx_byte;
  logic              out_valid, frame_err, fmt_err, overrun;
  logic [DATA_W-1:0] sample_x, sample_y, sample_z;
  logic [CNT_W-1:0]  frame_cnt;

  always #5 clk = ~clk;

  accel_frame_assembler #(
    .SKIP_BYTES (2),
    .AXES       (3),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .out_ready    (out_ready),
    .clear_status (clear_status),
    .out_valid    (out_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .frame_err    (frame_err),
    .fmt_err      (fmt_err),
    .overrun      (overrun),
    .frame_cnt    (frame_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] x, y, z;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               n_err_pulses = 0;
  int               exp_aborts = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  bit               model_fmt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules: sample = (hi mod 16)*256 + lo as 12-bit two's complement;
  // the top five bits of hi must be all zeros or all ones.
  function automatic logic [DATA_W-1:0] sample_of(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = (int'(hi) % 16) * 256 + int'(lo);
    return DATA_W'(v);
  endfunction

  function automatic bit hi_bad(input logic [7:0] hi);
    int top;
    top = int'(hi) / 8;
    return !(top == 0 || top == 31);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle gap first, then one byte for one cycle; returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit with_end, input int gap);
    repeat (gap) tick();
    rx_valid  = 1'b1;
    rx_byte   = b;
    frame_end = with_end;
    tick();
    rx_valid  = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  // Sends a frame with n_data data bytes. do_end=0 leaves the frame open.
  task automatic run_frame(input logic [7:0] d[6], input int n_data,
                           input bit end_on_last, input bit do_end, input int extra);
    bit   complete;
    exp_t e;
    complete = (n_data == 6);
    if ($urandom_range(0, 3) == 0) send_byte(8'hA5, 1'b0, 0);  // stray byte in IDLE
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_byte(READ_CMD, 1'b0, $urandom_range(0, 2));
    send_byte(XDATA_L_ADDR, 1'b0, $urandom_range(0, 2));
    for (int i = 0; i < n_data; i++) begin
      send_byte(d[i], do_end && end_on_last && (i == n_data - 1), $urandom_range(0, 2));
      if ((i % 2 == 1) && hi_bad(d[i])) model_fmt = 1'b1;
    end
    if (!do_end) return;
    if (!(end_on_last && n_data > 0)) begin
      if (complete) begin
        for (int k = 0; k < extra; k++) send_byte(8'($urandom), 1'b0, $urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 2)) tick();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
    end
    if (complete) begin
      model_cnt = model_cnt + 1'b1;
      e.x   = sample_of(d[0], d[1]);
      e.y   = sample_of(d[2], d[3]);
      e.z   = sample_of(d[4], d[5]);
      e.cnt = model_cnt;
      exp_q.push_back(e);
    end else begin
      exp_aborts++;
    end
  endtask

  // Monitor: every new commit is compared against the scoreboard head.
  initial begin
    logic [CNT_W-1:0] last_cnt;
    exp_t             e;
    last_cnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_cnt = '0;
      end else begin
        if (frame_err) n_err_pulses++;
        if (frame_cnt != last_cnt) begin
          last_cnt = frame_cnt;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_commit: got frame_cnt=%0d, expected no commit", frame_cnt);
          end else begin
            e = exp_q.pop_front();
            $display("commit cnt=%0d x=%03h y=%03h z=%03h", frame_cnt, sample_x, sample_y, sample_z);
            check("commit_x", 32'(sample_x), 32'(e.x));
            check("commit_y", 32'(sample_y), 32'(e.y));
            check("commit_z", 32'(sample_z), 32'(e.z));
            check("commit_cnt", 32'(frame_cnt), 32'(e.cnt));
            check("commit_valid", 32'(out_valid), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[6];
    rst = 1'b1; frame_start = 0; frame_end = 0; rx_valid = 0; rx_byte = 0;
    out_ready = 1'b1; clear_status = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sample_x", 32'(sample_x), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_fmt_err", 32'(fmt_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    tick();
    rst = 1'b0;
    tick();

    // Normal frame.
    d = '{8'h34, 8'h02, 8'hF0, 8'hFF, 8'h00, 8'h00};
    run_frame(d, 6, 1'b0, 1'b1, 0);
    @(posedge clk); @(negedge clk);
    check("normal_valid_drop", 32'(out_valid), 0);
    check("normal_fmt", 32'(fmt_err), 0);
    check("normal_overrun", 32'(overrun), 0);
    tick();

    // Sign-extension error in Z, then clear.
    d = '{8'h11, 8'h01, 8'h22, 8'h02, 8'h00, 8'h08};
    run_frame(d, 6, 1'b0, 1'b1, 1);
    @(negedge clk);
    check("fmt_set", 32'(fmt_err), 1);
    tick();
    pulse_clear();
    @(negedge clk);
    check("fmt_cleared", 32'(fmt_err), 0);
    model_fmt = 1'b0;
    tick();

    // Short frame: frame_end after 5 bytes.
    d = '{8'h34, 8'h02, 8'hF0, 8'hFF, 8'h00, 8'h00};
    run_frame(d, 3, 1'b0, 1'b1, 0);
    repeat (2) tick();
    @(negedge clk);
    check("short_valid", 32'(out_valid), 0);
    check("short_cnt", 32'(frame_cnt), 32'(model_cnt));
    tick();

    // Overrun with out_ready low.
    out_ready = 1'b0;
    d = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    run_frame(d, 6, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("ovr_first_clean", 32'(overrun), 0);
    tick();
    d = '{8'h55, 8'h07, 8'hAA, 8'hF8, 8'h0F, 8'hFF};
    run_frame(d, 6, 1'b1, 1'b1, 0);
    @(negedge clk);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_valid", 32'(out_valid), 1);
    check("ovr_second_x", 32'(sample_x), 32'h755);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_valid_before", 32'(out_valid), 1);
    @(posedge clk); @(negedge clk);
    check("hs_valid_after", 32'(out_valid), 0);
    tick();
    pulse_clear();
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 0);
    tick();

    // Last Z high byte together with frame_end.
    d = '{8'h9A, 8'h01, 8'h00, 8'hF8, 8'h7F, 8'h07};
    run_frame(d, 6, 1'b1, 1'b1, 0);
    tick();

    // Restart mid-DATA, then from WAIT_END, then a full frame.
    run_frame(d, 3, 1'b0, 1'b0, 0);
    exp_aborts++;
    run_frame(d, 6, 1'b0, 1'b0, 0);
    d = '{8'h12, 8'h03, 8'h34, 8'h04, 8'h56, 8'h05};
    run_frame(d, 6, 1'b0, 1'b1, 0);
    tick();

    // Async reset mid-DATA with a held sample in the output register.
    out_ready = 1'b0;
    run_frame(d, 6, 1'b0, 1'b1, 0);
    run_frame(d, 3, 1'b0, 1'b0, 0);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_x", 32'(sample_x), 0);
    check("arst_cnt", 32'(frame_cnt), 0);
    check("arst_fmt", 32'(fmt_err), 0);
    model_cnt = '0;
    model_fmt = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    d = '{8'hFE, 8'hFF, 8'h01, 8'h08, 8'h80, 8'h00};
    run_frame(d, 6, 1'b0, 1'b1, 0);
    tick();
    pulse_clear();
    model_fmt = 1'b0;

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int n;
      pulse_clear();
      model_fmt = 1'b0;
      for (int i = 0; i < 6; i += 2) begin
        logic [11:0] s;
        s = 12'($urandom);
        d[i]   = s[7:0];
        d[i+1] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : {{4{s[11]}}, s[11:8]};
      end
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 6;
      run_frame(d, n, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2));
      @(negedge clk);
      check($sformatf("rand%0d_fmt", f), 32'(fmt_err), 32'(model_fmt));
      tick();
    end

    repeat (5) tick();
    check("queue_drained", 32'(exp_q.size()), 0);
    check("frame_err_pulses", 32'(n_err_pulses), 32'(exp_aborts));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
